// File: rtl/gf_mul_lanes_pkg.sv
// Shared types and helpers for the multi-lane GF(2^8) multiplier.
// Byte fields are ascending [0:7] with index 0 as the MSB, matching the cipher datapath.
package gf_mul_lanes_pkg;

    localparam logic [7:0] AES_POLY = 8'h1b;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

    typedef logic [0:7] gf_t;

    // Bit n set means n bits per cycle is a supported setting.
    localparam logic [8:0] BPC_LEGAL_SET = 9'b1_0001_0110;

    function automatic bit bpc_legal(input int bpc);
        if (bpc < 1 || bpc > 8)
            return 1'b0;
        return BPC_LEGAL_SET[bpc[3:0]];
    endfunction

    function automatic gf_t xtime(input gf_t x, input logic [7:0] poly);
        return {x[1:7], 1'b0} ^ (x[0] ? poly : 8'h00);
    endfunction

endpackage

// File: rtl/gf_mul_lanes_step.sv
// One Horner step for a single lane: folds BPC multiplier bits (MSB first) into acc.
// Purely combinational so it can be checked on its own.
module gf_horner_step
    import gf_mul_lanes_pkg::*;
#(
    parameter int         BPC  = 1,
    parameter logic [7:0] POLY = AES_POLY
) (
    input  gf_t              acc,
    input  gf_t              a,
    input  logic [0:BPC-1]   bits,
    output gf_t              acc_next
);

    always_comb begin
        gf_t x;
        x = acc;
        for (int i = 0; i < BPC; i++)
            x = xtime(x, POLY) ^ (bits[i] ? a : 8'h00);
        acc_next = x;
    end

endmodule

// File: rtl/gf_mul_lanes.sv
// Multi-lane GF(2^8) multiplier with valid/ready on both sides.
// Each lane runs an independent Horner chain; one operation occupies the block for 8/BPC cycles.
module gf_mul_lanes
    import gf_mul_lanes_pkg::*;
#(
    parameter int         LANES = 4,
    parameter logic [7:0] POLY  = AES_POLY,
    parameter int         BPC   = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [0:8*LANES-1] a_i,
    input  logic [0:8*LANES-1] b_i,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [0:8*LANES-1] p_o
);

    localparam int STEPS = 8 / BPC;
    localparam int SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);

    if (!bpc_legal(BPC)) begin : g_bpc_check
        $error("gf_mul_lanes: BPC must be 1, 2, 4 or 8");
    end

    state_e state, state_nxt;
    logic [SW-1:0] step;

    gf_t [0:LANES-1] a_q;
    gf_t [0:LANES-1] b_q;
    gf_t [0:LANES-1] acc_q;
    gf_t [0:LANES-1] acc_nxt;

    // b_q is shifted toward index 0 each cycle, so the next bits are always at [0:BPC-1].
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        gf_horner_step #(
            .BPC  (BPC),
            .POLY (POLY)
        ) u_step (
            .acc      (acc_q[k]),
            .a        (a_q[k]),
            .bits     (b_q[k][0:BPC-1]),
            .acc_next (acc_nxt[k])
        );
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)     state_nxt = RUN;
            RUN:     if (step == LAST) state_nxt = DONE;
            DONE:    if (out_ready)    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            p_o   <= '0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= a_i;
                        b_q   <= b_i;
                        acc_q <= '0;
                        step  <= '0;
                    end
                end
                RUN: begin
                    acc_q <= acc_nxt;
                    step  <= step + 1'b1;
                    for (int k = 0; k < LANES; k++)
                        b_q[k] <= b_q[k] << BPC;
                    if (step == LAST)
                        p_o <= acc_nxt;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mul_lanes.sv
// Directed bench for gf_mul_lanes: one DUT per BPC setting (1, 2, 4, 8) sharing operand buses.
module tb_gf_mul_lanes;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [0:31] a_i = '0;
    logic [0:31] b_i = '0;
    logic        in_valid  [4];
    logic        out_ready [4];
    logic        in_ready  [4];
    logic        out_valid [4];
    logic [0:31] p_o       [4];

    int tests = 0;
    int fails = 0;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        gf_mul_lanes #(
            .LANES (4),
            .POLY  (8'h1b),
            .BPC   (1 << g)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (in_valid[g]),
            .in_ready  (in_ready[g]),
            .a_i       (a_i),
            .b_i       (b_i),
            .out_valid (out_valid[g]),
            .out_ready (out_ready[g]),
            .p_o       (p_o[g])
        );
    end

    always #5 clk = ~clk;

    // Shift-and-add, LSB-first reference multiply.
    function automatic logic [7:0] gmul(input logic [7:0] x, input logic [7:0] y);
        logic [7:0] p  = 8'h00;
        logic [7:0] aa = x;
        logic [7:0] bb = y;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p ^= aa;
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // Issue one operation on DUT idx; returns product and edges from accept to out_valid.
    task automatic run_op(input int idx, input logic [0:31] a, input logic [0:31] b,
                          output logic [0:31] p, output int lat);
        a_i = a;
        b_i = b;
        in_valid[idx] = 1'b1;
        @(posedge clk); #1;
        in_valid[idx] = 1'b0;
        lat = 0;
        while (!out_valid[idx] && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        p = p_o[idx];
        if (out_ready[idx]) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (in_ready[i] !== 1'b1) begin
                fails++; $display("FAIL reset_in_ready[%0d]: got %b expected 1", i, in_ready[i]);
            end
            tests++;
            if (out_valid[i] !== 1'b0) begin
                fails++; $display("FAIL reset_out_valid[%0d]: got %b expected 0", i, out_valid[i]);
            end
            tests++;
            if (p_o[i] !== 32'h0) begin
                fails++; $display("FAIL reset_p_o[%0d]: got %h expected 00000000", i, p_o[i]);
            end
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_fips();
        logic [0:31] p;
        int lat;
        run_op(0, 32'h57_57_00_01, 32'h83_13_ff_01, p, lat);
        tests++;
        if (p !== 32'hc1_fe_00_01) begin
            fails++; $display("FAIL fips_product: got %h expected c1fe0001", p);
        end
        tests++;
        if (lat !== 8) begin
            fails++; $display("FAIL fips_latency: got %0d expected 8", lat);
        end
    endtask

    task automatic test_column();
        logic [0:31] p;
        logic [7:0]  x;
        int lat;
        for (int i = 0; i < 4; i++) begin
            run_op(i, 32'h8e_4d_a1_bc, 32'h0e_0b_0d_09, p, lat);
            x = p[0:7] ^ p[8:15] ^ p[16:23] ^ p[24:31];
            tests++;
            if (x !== 8'hdb) begin
                fails++; $display("FAIL column_xor bpc=%0d: got %h expected db", 1 << i, x);
            end
            tests++;
            if (lat !== (8 >> i)) begin
                fails++; $display("FAIL column_latency bpc=%0d: got %0d expected %0d", 1 << i, lat, 8 >> i);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [0:31] p;
        int lat;
        run_op(0, 32'h57_57_00_01, 32'h83_13_ff_01, p, lat);
        tests++;
        if (in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL b2b_ready: got %b expected 1", in_ready[0]);
        end
        run_op(0, 32'h01_02_ff_00, 32'hff_80_01_37, p, lat);
        tests++;
        if (p !== 32'hff_1b_ff_00) begin
            fails++; $display("FAIL b2b_product: got %h expected ff1bff00", p);
        end
    endtask

    task automatic test_backpressure();
        logic [0:31] p;
        int lat;
        int bad = 0;
        out_ready[0] = 1'b0;
        run_op(0, 32'h57_57_00_01, 32'h83_13_ff_01, p, lat);
        tests++;
        if (p !== 32'hc1_fe_00_01 || lat !== 8) begin
            fails++; $display("FAIL bp_first: got %h lat %0d expected c1fe0001 lat 8", p, lat);
        end
        for (int c = 0; c < 20; c++) begin
            a_i = 32'hdead_beef + c;
            b_i = 32'h1234_5678 ^ c;
            in_valid[0] = 1'b1;
            @(posedge clk); #1;
            if (p_o[0] !== 32'hc1_fe_00_01 || out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0) bad++;
        end
        in_valid[0] = 1'b0;
        tests++;
        if (bad != 0) begin
            fails++; $display("FAIL bp_hold: got %0d bad cycles expected 0", bad);
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (out_valid[0] !== 1'b0 || in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL bp_release: got valid %b ready %b expected valid 0 ready 1",
                              out_valid[0], in_ready[0]);
        end
    endtask

    task automatic test_reset_mid_run();
        logic [0:31] p;
        int lat;
        int stale = 0;
        a_i = 32'h57_57_00_01;
        b_i = 32'h83_13_ff_01;
        in_valid[0] = 1'b1;
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        tests++;
        if (out_valid[0] !== 1'b0 || p_o[0] !== 32'h0 || in_ready[0] !== 1'b1) begin
            fails++; $display("FAIL mid_reset: got valid %b p %h ready %b expected 0 00000000 1",
                              out_valid[0], p_o[0], in_ready[0]);
        end
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid[0] !== 1'b0) stale++;
        end
        tests++;
        if (stale != 0) begin
            fails++; $display("FAIL mid_reset_stale: got %0d valid cycles expected 0", stale);
        end
        run_op(0, 32'h57_57_57_57, 32'h83_83_83_83, p, lat);
        tests++;
        if (p !== 32'hc1_c1_c1_c1) begin
            fails++; $display("FAIL mid_reset_after: got %h expected c1c1c1c1", p);
        end
    endtask

    task automatic test_soak(input int idx, input int nops);
        logic [0:31] a, b, e;
        int  done_cnt = 0;
        int  cyc;
        bit  done;
        for (int n = 0; n < nops; n++) begin
            repeat ($urandom_range(0, 2)) begin
                a_i = $urandom; b_i = $urandom;
                @(posedge clk); #1;
            end
            a = $urandom;
            b = $urandom;
            for (int l = 0; l < 4; l++)
                e[8*l +: 8] = gmul(a[8*l +: 8], b[8*l +: 8]);
            a_i = a;
            b_i = b;
            in_valid[idx] = 1'b1;
            @(posedge clk); #1;
            done = 1'b0;
            cyc  = 0;
            while (!done && cyc < 100) begin
                a_i = $urandom;
                b_i = $urandom;
                in_valid[idx]  = 1'($urandom_range(0, 1));
                out_ready[idx] = 1'($urandom_range(0, 1));
                if (out_valid[idx] && out_ready[idx]) begin
                    done = 1'b1;
                    done_cnt++;
                    tests++;
                    if (p_o[idx] !== e) begin
                        fails++;
                        $display("FAIL soak bpc=%0d op %0d: got %h expected %h", 1 << idx, n, p_o[idx], e);
                    end
                end
                @(posedge clk); #1;
                cyc++;
            end
            in_valid[idx]  = 1'b0;
            out_ready[idx] = 1'b1;
            tests++;
            if (out_valid[idx] !== 1'b0) begin
                fails++; $display("FAIL soak_dup bpc=%0d op %0d: got valid 1 expected 0", 1 << idx, n);
            end
        end
        tests++;
        if (done_cnt != nops) begin
            fails++; $display("FAIL soak_count bpc=%0d: got %0d expected %0d", 1 << idx, done_cnt, nops);
        end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) begin
            in_valid[i]  = 1'b0;
            out_ready[i] = 1'b1;
        end
        test_reset();
        test_fips();
        test_column();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_run();
        for (int i = 0; i < 4; i++)
            test_soak(i, 150);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
